board_judge: RTL and testbench
==============================

Name: board_judge

Overview:
- Reads the 4x4 game board that the move FSM writes (16 cells, 4 bits each).
- Decides whether a player has won or the game is a draw.
- Triggered by a start pulse. Snapshots the board, then scans the 10 winning lines one per cycle.
- Returns a registered verdict with a done pulse. Results feed the score 7-seg decoders and the VGA overlay.

Parameters:
- CELL_W, 4, width of one cell code.
- P1_CODE, 1, cell code for player 1.
- P2_CODE, 2, cell code for player 2. Any code other than P1_CODE or P2_CODE counts as empty.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a judgement; sampled only in IDLE.
- cells  in  16*CELL_W  board, cell k (1..16) at bits [k*CELL_W-1 : (k-1)*CELL_W], row-major, cell 1 top-left.
- busy  out  1  high while snapshot or scan is in progress.
- done  out  1  one-cycle pulse when the verdict is valid.
- winner  out  2  0 none, 1 player 1, 2 player 2 (3 never driven).
- win_line  out  4  index of the winning line 0..9; 15 when there is no winner.
- draw  out  1  no winner and all 16 cells hold P1_CODE or P2_CODE.
- filled  out  5  number of cells holding P1_CODE or P2_CODE (0..16).

Behaviour:
- Reset (rst=0, async) sets:
  - state IDLE; busy=0, done=0.
  - winner=0, win_line=15, draw=0, filled=0.
  - Internal snapshot and line index cleared.
  - Reset mid-scan aborts the scan with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at edge T0: capture cells into the snapshot register, set line index to 0, clear the internal winner/line/filled accumulators, then go to SCAN.
  - busy=1 from the cycle after T0.
  - Published outputs keep their previous verdict until DONE.
- SCAN: one line per edge, T1..T10, evaluating line index 0..9.
  - Lines 0-3 are rows 0-3; lines 4-7 are columns 0-3; line 8 is the main diagonal (cells 1,6,11,16); line 9 is the anti-diagonal (cells 4,7,10,13).
  - A line wins when all 4 snapshot cells equal P1_CODE, or all 4 equal P2_CODE.
  - The first winning line, by lowest index, is latched. Later winning lines are ignored, including a line won by the other player.
  - During lines 0-3, the count of filled cells in that row is added to the filled accumulator. After line 3 the accumulator holds the full-board count, since rows cover all cells.
  - At T10 (line 9), go to DONE.
- DONE (one cycle):
  - Publish winner, win_line, filled.
  - draw = (no winner) and (filled == 16).
  - done=1 and busy=0 in this cycle; return to IDLE on the next edge.
- Latency: done is high in the 11th cycle after the start edge T0. The verdict holds until the next DONE.
- start while busy or in DONE is ignored; it is not queued.
- Changes to cells after T0 do not affect the current verdict (snapshot only).
- start held high continuously re-triggers a judgement every 12 cycles. The IDLE edge after DONE samples start.
- A winner takes priority over draw: a full board with a winning line gives draw=0.
- filled counts valid codes only; invalid codes count as empty and never match any line.

Test Plan:
- Reset, then start with cells 1-4 = 1 and all others 0:
  - busy rises the next cycle and done pulses 11 cycles after start.
  - Verdict: winner=1, win_line=0, draw=0, filled=4.
- Anti-diagonal cells 4,7,10,13 = 2 and cells 1,2 = 1 → winner=2, win_line=9, filled=6.
- Full board with no line (rows 1,1,2,2 / 2,2,1,1 / 1,1,2,2 / 2,2,1,1):
  - Verdict: winner=0, win_line=15, draw=1, filled=16.
- Row 1 (cells 5-8) and column 2 (cells 3,7,11,15) both = 1:
  - Verdict: win_line=1 (lowest index wins).
- Pulse start, overwrite cells 1-4 to 1 on cycle 3, and pulse start again on cycle 5:
  - Exactly one done, at cycle 11.
  - Verdict reflects the original snapshot.
- Start, assert rst=0 on cycle 6 of the scan:
  - All outputs return to reset values immediately, and no done pulse follows.
- Cells 1-4 = 5 (invalid code):
  - Verdict: winner=0, filled=0, draw=0.

Source files
------------

// File: rtl/board_judge.sv
// -----------------------------------------------------------------------------
// board_judge
//
// Judges a 4x4 game board. On a start request in IDLE the board is copied into
// a snapshot, then the 10 winning lines (rows 0-3, columns 0-3, main diagonal,
// anti-diagonal) are examined one per cycle. The first winning line (lowest
// index) is kept, the filled-cell count is accumulated from the four rows, and
// the verdict is published together with a one-cycle done pulse.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   start      judgement request, sampled only in IDLE
//   cells      board, cell k (1..16) at [k*CELL_W-1 -: CELL_W], row-major
//   busy       high while the scan is in progress
//   done       one-cycle pulse, verdict outputs valid from this cycle on
//   winner     0 none, 1 player 1, 2 player 2
//   win_line   winning line index 0..9, 15 when there is no winner
//   draw       no winner and all 16 cells hold a player code
//   filled     number of cells holding a player code (0..16)
//   dbg_state  current FSM state (0 IDLE, 1 SCAN, 2 DONE)
//
// Handshake: start is a level sampled on each rising edge while IDLE; requests
// made in any other state are dropped, not queued. done carries no back
// pressure; winner/win_line/draw/filled are valid while done=1 and hold until
// the next done.
// -----------------------------------------------------------------------------
module board_judge #(
    parameter int                 CELL_W  = 4,
    parameter logic [CELL_W-1:0]  P1_CODE = CELL_W'(1),
    parameter logic [CELL_W-1:0]  P2_CODE = CELL_W'(2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [16*CELL_W-1:0]  cells,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            winner,
    output logic [3:0]            win_line,
    output logic                  draw,
    output logic [4:0]            filled,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [3:0] NO_LINE   = 4'd15;
    localparam logic [3:0] LAST_LINE = 4'd9;

    state_e               state_q,        state_d;
    logic [16*CELL_W-1:0] snap_q,         snap_d;
    logic [3:0]           line_q,         line_d;
    logic [1:0]           acc_winner_q,   acc_winner_d;
    logic [3:0]           acc_line_q,     acc_line_d;
    logic [4:0]           acc_filled_q,   acc_filled_d;
    logic [1:0]           winner_q,       winner_d;
    logic [3:0]           win_line_q,     win_line_d;
    logic                 draw_q,         draw_d;
    logic [4:0]           filled_q,       filled_d;

    // Cell indices (0-based) of the line currently under examination.
    logic [3:0]           idx      [4];
    logic [CELL_W-1:0]    line_val [4];
    logic                 all_p1;
    logic                 all_p2;
    logic [2:0]           line_cnt;

    always_comb begin
        all_p1   = 1'b1;
        all_p2   = 1'b1;
        line_cnt = 3'd0;
        for (int j = 0; j < 4; j++) begin
            if (line_q < 4'd4) begin
                idx[j] = {line_q[1:0], 2'(j)};          // row: r*4 + j
            end else if (line_q < 4'd8) begin
                idx[j] = {2'(j), line_q[1:0]};          // column: j*4 + c
            end else if (line_q == 4'd8) begin
                idx[j] = {2'(j), 2'(j)};                // 0,5,10,15
            end else begin
                idx[j] = {2'(j), ~2'(j)};               // 3,6,9,12
            end
            line_val[j] = snap_q[int'(idx[j])*CELL_W +: CELL_W];
            all_p1 = all_p1 & (line_val[j] == P1_CODE);
            all_p2 = all_p2 & (line_val[j] == P2_CODE);
            if (line_val[j] == P1_CODE || line_val[j] == P2_CODE) begin
                line_cnt = line_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        line_d       = line_q;
        acc_winner_d = acc_winner_q;
        acc_line_d   = acc_line_q;
        acc_filled_d = acc_filled_q;
        winner_d     = winner_q;
        win_line_d   = win_line_q;
        draw_d       = draw_q;
        filled_d     = filled_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d       = cells;
                    line_d       = 4'd0;
                    acc_winner_d = 2'd0;
                    acc_line_d   = NO_LINE;
                    acc_filled_d = 5'd0;
                    state_d      = S_SCAN;
                end
            end
            S_SCAN: begin
                // Only the first winning line is kept; later wins, even by the
                // other player, are ignored.
                if (acc_winner_q == 2'd0 && (all_p1 || all_p2)) begin
                    acc_winner_d = all_p1 ? 2'd1 : 2'd2;
                    acc_line_d   = line_q;
                end
                // The four rows partition the board, so counting during the
                // row lines yields the full-board count.
                if (line_q < 4'd4) begin
                    acc_filled_d = acc_filled_q + 5'(line_cnt);
                end
                if (line_q == LAST_LINE) begin
                    // Publish on this edge so the verdict is already valid in
                    // the DONE cycle alongside the done pulse.
                    winner_d   = acc_winner_d;
                    win_line_d = acc_line_d;
                    filled_d   = acc_filled_d;
                    draw_d     = (acc_winner_d == 2'd0) && (acc_filled_d == 5'd16);
                    state_d    = S_DONE;
                end else begin
                    line_d = line_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            snap_q       <= '0;
            line_q       <= 4'd0;
            acc_winner_q <= 2'd0;
            acc_line_q   <= NO_LINE;
            acc_filled_q <= 5'd0;
            winner_q     <= 2'd0;
            win_line_q   <= NO_LINE;
            draw_q       <= 1'b0;
            filled_q     <= 5'd0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            line_q       <= line_d;
            acc_winner_q <= acc_winner_d;
            acc_line_q   <= acc_line_d;
            acc_filled_q <= acc_filled_d;
            winner_q     <= winner_d;
            win_line_q   <= win_line_d;
            draw_q       <= draw_d;
            filled_q     <= filled_d;
        end
    end

    assign busy      = (state_q == S_SCAN);
    assign done      = (state_q == S_DONE);
    assign winner    = winner_q;
    assign win_line  = win_line_q;
    assign draw      = draw_q;
    assign filled    = filled_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_board_judge.sv
module tb_board_judge;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] cells;
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic [3:0]  win_line;
    logic        draw;
    logic [4:0]  filled;
    logic [1:0]  dbg_state;

    board_judge dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cells     (cells),
        .busy      (busy),
        .done      (done),
        .winner    (winner),
        .win_line  (win_line),
        .draw      (draw),
        .filled    (filled),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    // expected verdict packed as {winner[1:0], win_line[3:0], draw, filled[4:0]}
    logic [11:0] exp_q[$];
    int          exp_cyc_q[$];
    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;

    logic [3:0]  brd [16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] verdict(input int w, input int l, input int d, input int f);
        return {2'(w), 4'(l), 1'(d), 5'(f)};
    endfunction

    function automatic logic [63:0] pack_brd();
        logic [63:0] v;
        for (int k = 0; k < 16; k++) v[k*4 +: 4] = brd[k];
        return v;
    endfunction

    task automatic clear_brd();
        for (int k = 0; k < 16; k++) brd[k] = 4'd0;
    endtask

    // cell numbers are 1-based as on the board drawing
    task automatic set_cell(input int k, input logic [3:0] v);
        brd[k-1] = v;
    endtask

    // monitor: pops and compares whenever the DUT presents done
    always @(negedge clk) begin
        logic [11:0] e;
        int          ec;
        if (rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk("done_cycle", cyc, ec);
                chk("busy_in_done", busy, 0);
                chk("winner", winner, e[11:10]);
                chk("win_line", win_line, e[9:6]);
                chk("draw", draw, e[5]);
                chk("filled", filled, e[4:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("done_timeout_pending", exp_q.size(), 0);
            exp_q.delete();
            exp_cyc_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_judge(input logic [11:0] exp);
        @(negedge clk);
        cells = pack_brd();
        start = 1'b1;
        exp_q.push_back(exp);
        exp_cyc_q.push_back(cyc + 11);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        wait_drain();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_winner"}, winner, 0);
        chk({tag, "_win_line"}, win_line, 15);
        chk({tag, "_draw"}, draw, 0);
        chk({tag, "_filled"}, filled, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        rst   = 1'b0;
        start = 1'b0;
        cells = '0;
        clear_brd();
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);

        // top row player 1
        clear_brd();
        for (int k = 1; k <= 4; k++) set_cell(k, 4'd1);
        run_judge(verdict(1, 0, 0, 4));
        chk("busy_idle_after_done", busy, 0);

        // anti-diagonal player 2 plus two player-1 cells
        clear_brd();
        set_cell(4, 4'd2); set_cell(7, 4'd2); set_cell(10, 4'd2); set_cell(13, 4'd2);
        set_cell(1, 4'd1); set_cell(2, 4'd1);
        run_judge(verdict(2, 9, 0, 6));

        // full board, no line -> draw
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                brd[r*4+c] = (((r % 2) == 0) == (c < 2)) ? 4'd1 : 4'd2;
        run_judge(verdict(0, 15, 1, 16));

        // row 1 and column 2 both player 1: lowest index wins
        clear_brd();
        for (int k = 5; k <= 8; k++) set_cell(k, 4'd1);
        set_cell(3, 4'd1); set_cell(11, 4'd1); set_cell(15, 4'd1);
        run_judge(verdict(1, 1, 0, 7));

        // invalid codes count as empty and never win
        clear_brd();
        for (int k = 1; k <= 4; k++) set_cell(k, 4'd5);
        run_judge(verdict(0, 15, 0, 0));

        // full board with P2 row 0 and P1 row 3: winner beats draw, first line kept
        for (int k = 1; k <= 4; k++) set_cell(k, 4'd2);
        set_cell(5, 4'd1); set_cell(6, 4'd1); set_cell(7, 4'd2); set_cell(8, 4'd2);
        set_cell(9, 4'd2); set_cell(10, 4'd2); set_cell(11, 4'd1); set_cell(12, 4'd1);
        for (int k = 13; k <= 16; k++) set_cell(k, 4'd1);
        run_judge(verdict(2, 0, 0, 16));

        // column 3 player 2 and main diagonal player 1
        clear_brd();
        set_cell(4, 4'd2); set_cell(8, 4'd2); set_cell(12, 4'd2); set_cell(16, 4'd2);
        run_judge(verdict(2, 7, 0, 4));
        clear_brd();
        set_cell(1, 4'd1); set_cell(6, 4'd1); set_cell(11, 4'd1); set_cell(16, 4'd1);
        run_judge(verdict(1, 8, 0, 4));

        // snapshot: board changes and a second start during the scan are ignored
        clear_brd();
        for (int k = 5; k <= 8; k++) set_cell(k, 4'd2);
        d0 = done_cnt;
        @(negedge clk);
        cells = pack_brd();
        start = 1'b1;
        exp_q.push_back(verdict(2, 1, 0, 4));
        exp_cyc_q.push_back(cyc + 11);
        @(negedge clk);                 // cycle 1
        start = 1'b0;
        @(negedge clk);                 // cycle 2
        @(negedge clk);                 // cycle 3
        for (int k = 1; k <= 4; k++) set_cell(k, 4'd1);
        cells = pack_brd();
        @(negedge clk);                 // cycle 4
        @(negedge clk);                 // cycle 5
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (4) @(negedge clk);
        chk("snapshot_done_count", done_cnt - d0, 1);

        // start held high re-triggers every 12 cycles
        clear_brd();
        for (int k = 9; k <= 12; k++) set_cell(k, 4'd1);
        @(negedge clk);
        cells = pack_brd();
        start = 1'b1;
        exp_q.push_back(verdict(1, 2, 0, 4));
        exp_cyc_q.push_back(cyc + 11);
        exp_q.push_back(verdict(1, 2, 0, 4));
        exp_cyc_q.push_back(cyc + 23);
        repeat (14) @(negedge clk);
        start = 1'b0;
        wait_drain();

        // reset during the scan: outputs back to reset values, no done follows
        clear_brd();
        for (int k = 13; k <= 16; k++) set_cell(k, 4'd2);
        @(negedge clk);
        cells = pack_brd();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);      // cycle 6 of the scan
        rst = 1'b0;
        #1;
        chk_reset_values("abort");
        @(negedge clk);
        rst = 1'b1;
        d0 = done_cnt;
        repeat (15) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_idle_state", dbg_state, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
